// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the 4-input round-robin write arbiter.
// Lane encodings are shared with the muxed register bank.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned SELSIZE = 2;
  localparam int unsigned CNTW    = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [SELSIZE-1:0] LANE1 = 2'b00;
  localparam logic [SELSIZE-1:0] LANE2 = 2'b01;
  localparam logic [SELSIZE-1:0] LANE3 = 2'b10;
  localparam logic [SELSIZE-1:0] LANE4 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_RECOVER = ST_RECOVER
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/bank-side bundle of the arbiter. grant_cnt and its width parameter
// exist only when ARB_GRANT_CNT_EN is defined.
interface mux4_rr_arbiter_if
`ifdef ARB_GRANT_CNT_EN
  #(parameter int unsigned CNTW = mux4_rr_arbiter_pkg::CNTW)
`endif
  ;
  import mux4_rr_arbiter_pkg::*;

  logic [NREQ-1:0]    req;
  logic               stall;
  logic [SELSIZE-1:0] select;
  logic               wr_en;
  logic [NREQ-1:0]    ack;
  logic               busy;
`ifdef ARB_GRANT_CNT_EN
  logic [CNTW-1:0]    grant_cnt;
`endif

  // Requester / environment side
  modport master (
    output req, stall,
    input  select, wr_en, ack, busy
`ifdef ARB_GRANT_CNT_EN
    , input grant_cnt
`endif
  );

  // Arbiter side
  modport slave (
    input  req, stall,
    output select, wr_en, ack, busy
`ifdef ARB_GRANT_CNT_EN
    , output grant_cnt
`endif
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around; the pointed-to source itself is checked last.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]    req,
  input  logic [SELSIZE-1:0] ptr,
  output logic               any,
  output logic [SELSIZE-1:0] win
);

  logic [SELSIZE-1:0] idx;
  logic               found;

  always_comb begin
    any   = |req;
    win   = LANE1;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr + SELSIZE'(k) + SELSIZE'(1);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin write arbiter in front of the 4-input muxed register bank.
// Optional grant counter enabled by defining ARB_GRANT_CNT_EN.
module mux4_rr_arbiter
`ifdef ARB_GRANT_CNT_EN
  #(parameter int unsigned CNTW = mux4_rr_arbiter_pkg::CNTW)
`endif
(
  input  logic              clk,
  input  logic              rst,
  mux4_rr_arbiter_if.slave  bus
);
  import mux4_rr_arbiter_pkg::*;

  state_t             state_q, state_nx;
  logic [SELSIZE-1:0] ptr_q, ptr_nx;
  logic [SELSIZE-1:0] sel_q, sel_nx;
  logic               wr_q, wr_nx;
  logic [NREQ-1:0]    ack_q, ack_nx;
  logic               busy_q;
  logic               any_c;
  logic [SELSIZE-1:0] win_c;
`ifdef ARB_GRANT_CNT_EN
  logic [CNTW-1:0]    cnt_q, cnt_nx;
`endif

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (any_c),
    .win (win_c)
  );

  // State and output registers; reset drops any grant in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= LANE4;
      sel_q   <= LANE1;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
`ifdef ARB_GRANT_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_nx;
      ptr_q   <= ptr_nx;
      sel_q   <= sel_nx;
      wr_q    <= wr_nx;
      ack_q   <= ack_nx;
      busy_q  <= (state_nx != S_IDLE);
`ifdef ARB_GRANT_CNT_EN
      cnt_q   <= cnt_nx;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state_q;
    ptr_nx   = ptr_q;
    sel_nx   = sel_q;
    wr_nx    = 1'b0;
    ack_nx   = '0;
`ifdef ARB_GRANT_CNT_EN
    cnt_nx   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any_c && !bus.stall) begin
          sel_nx   = win_c;
          ack_nx   = NREQ'(1) << win_c;
          wr_nx    = 1'b1;
          ptr_nx   = win_c;
          state_nx = S_ISSUE;
`ifdef ARB_GRANT_CNT_EN
          cnt_nx   = cnt_q + CNTW'(1);
`endif
        end
      end
      // The write is committed once issued; stall cannot cancel it
      S_ISSUE:   state_nx = S_RECOVER;
      // Dead cycle so the acked requester can drop or refresh req
      S_RECOVER: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  assign bus.select = sel_q;
  assign bus.wr_en  = wr_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
`ifdef ARB_GRANT_CNT_EN
  assign bus.grant_cnt = cnt_q;
`endif

endmodule
